rotary_value_select: RTL and testbench
======================================

# rotary_value_select

Consumes the rotary decoder's single-cycle `rotary_event` / `rotary_left` pair and maintains a bounded, user-adjustable value. The value is stepped up or down per detent. A debounced push-button commits the current value into a valid/ready handshake. Sits between the rotary front end and the I2C master command path, which takes `commit_data` as the byte to transmit.

## Interface
- `WIDTH`, 8: bit width of value and commit data.
- `MIN_VAL`, 0: lowest legal value.
- `MAX_VAL`, 255: highest legal value. Requires `MIN_VAL <= INIT_VAL <= MAX_VAL <= 2^WIDTH-1`.
- `INIT_VAL`, 0: value after reset.
- `WRAP`, 1: 1 = wrap at limits; 0 = saturate at limits.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles needed to accept a button level change. Must be >= 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rotary_event`  in  1  one-cycle pulse per detent, synchronous to `clk`.
- `rotary_left`  in  1  direction, valid when `rotary_event`=1. 1 = decrement, 0 = increment.
- `btn`  in  1  raw, asynchronous, bouncing push-button; active-high.
- `value`  out  WIDTH  current selected value.
- `commit_valid`  out  1  commit request pending.
- `commit_data`  out  WIDTH  value captured at commit; stable while `commit_valid`=1.
- `commit_ready`  in  1  consumer accepts when `commit_valid` and `commit_ready` are both 1 at a rising edge.
- `commit_dropped`  out  1  one-cycle pulse: a press was discarded because a commit was already pending.

## Operation
- Reset values (`reset_n`=0, immediate): `value`=INIT_VAL, `commit_valid`=0, `commit_data`=0, `commit_dropped`=0. Internally: debounced level=0, debounce counter=0, sync flops=0, FSM=IDLE.
- **Value stepping.** Each `rotary_event`=1 cycle changes `value` by exactly 1 at the same edge. If `rotary_event`=0, `value` holds.
  - Increment at MAX_VAL: WRAP=1 gives MIN_VAL; WRAP=0 holds MAX_VAL.
  - Decrement at MIN_VAL: WRAP=1 gives MAX_VAL; WRAP=0 holds MIN_VAL.
  - Compare against the limits, never against 2^WIDTH, so non-power-of-two ranges behave correctly.
- **Button conditioning.**
  - Two-flop synchronizer on `btn`.
  - A counter runs while the synchronized level differs from the debounced level and clears to 0 on any cycle where they match.
  - On a mismatching cycle with counter = DEBOUNCE_CYCLES-1, the debounced level toggles at that edge and the counter clears.
  - A press is a 0→1 transition of the debounced level, detected against a one-cycle-delayed copy. Releases produce no event.
- **Commit FSM.**
  - IDLE: on press, `commit_data`←`value` (pre-update value if `rotary_event` fires in the same cycle), `commit_valid`←1, go to HOLD.
  - HOLD: `commit_data` is frozen. When `commit_valid`&`commit_ready`, `commit_valid`←0 and go to IDLE. A press in HOLD is discarded and `commit_dropped` pulses for 1 cycle, including a press in the same cycle as the handshake.
- Rotation is never blocked; `value` keeps tracking detents in both states.

## Timing
- `value` changes at the edge where `rotary_event`=1 is sampled; it is visible the following cycle.
- `btn` first sampled high at edge E (bounce-free) → debounced level rises at edge E+DEBOUNCE_CYCLES+1 → `commit_valid` rises at edge E+DEBOUNCE_CYCLES+2.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no press.
- A handshake at edge H gives `commit_valid`=0 after H. The earliest new press can assert `commit_valid` at H+1.
- `commit_ready` may be held high permanently: valid is then high for exactly 1 cycle per commit.
- `reset_n` asserted mid-HOLD or mid-debounce: everything returns to reset values immediately. No commit is emitted after release until a fresh full debounce completes.

## Test plan
- WRAP=1, MIN=0, MAX=9, INIT=0: 11 increment events give `value` 1..9, 0, 1; then 2 decrements give 0, 9.
- WRAP=0, MIN=3, MAX=5, INIT=4: 3 increments give 5, 5, 5; 4 decrements give 4, 3, 3, 3.
- DEBOUNCE_CYCLES=8: pulse `btn` high 5 cycles → no `commit_valid`. Hold `btn` high from edge E → `commit_valid` rises at E+10 with `commit_data`=`value`.
- `commit_ready`=0, value=7: press → valid, data=7. Rotate to 9 → data stays 7. Second press → `commit_dropped` pulses. Raise `commit_ready` → valid falls the next cycle.
- Press and `rotary_event` (increment) in the same cycle with value=4 → `commit_data`=4, `value`=5.
- Assert `reset_n`=0 during HOLD → `commit_valid`=0 and `value`=INIT_VAL immediately. After release with `btn` still held high, `commit_valid` rises DEBOUNCE_CYCLES+2 edges after the first high sample.

Source files
------------

// File: rtl/rotary_value_select_if.sv
// Commit handshake bundle between the value selector
// and the downstream I2C command path.
interface rotary_value_select_if #(
  parameter int WIDTH = 8
) ();
  logic             commit_valid;
  logic [WIDTH-1:0] commit_data;
  logic             commit_ready;

  modport master (
    output commit_valid,
    output commit_data,
    input  commit_ready
  );

  modport slave (
    input  commit_valid,
    input  commit_data,
    output commit_ready
  );
endinterface

// File: rtl/rotary_value_select.sv
// Bounded rotary-stepped value with a debounced
// push-button commit over a valid/ready handshake.
module rotary_value_select #(
  parameter int WIDTH           = 8,
  parameter int MIN_VAL         = 0,
  parameter int MAX_VAL         = 255,
  parameter int INIT_VAL        = 0,
  parameter int WRAP            = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rotary_event,
  input  logic             rotary_left,
  input  logic             btn,
  output logic [WIDTH-1:0] value,
  output logic             commit_dropped,
  rotary_value_select_if.master commit
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [WIDTH-1:0] MINV = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIV = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [CW-1:0]    CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    CONE = CW'(1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d1_q;
  logic [CW-1:0]    cnt_q;
  logic             press;
  state_t           state_q;
  state_t           state_d;
  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             drop_q;
  logic             drop_d;

  // Limits are compared directly so odd ranges wrap cleanly
  always_comb begin
    value_d = value_q;
    if (rotary_event) begin
      if (rotary_left) begin
        if (value_q == MINV)
          value_d = (WRAP != 0) ? MAXV : MINV;
        else
          value_d = value_q - ONE;
      end else begin
        if (value_q == MAXV)
          value_d = (WRAP != 0) ? MINV : MAXV;
        else
          value_d = value_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= INIV;
    end else begin
      value_q <= value_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      deb_q    <= 1'b0;
      deb_d1_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      deb_d1_q <= deb_q;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CMAX) begin
        cnt_q <= '0;
        deb_q <= ~deb_q;
      end else begin
        cnt_q <= cnt_q + CONE;
      end
    end
  end

  assign press = deb_q & ~deb_d1_q;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    drop_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          data_d  = value_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && commit.commit_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
        if (press)
          drop_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign value               = value_q;
  assign commit_dropped      = drop_q;
  assign commit.commit_valid = valid_q;
  assign commit.commit_data  = data_q;

endmodule

// File: tb/tb_rotary_value_select.sv
// Directed bench for rotary_value_select: wrap and
// saturate stepping, debounce, commit and reset.
module tb_rotary_value_select;

  logic       clk;
  logic       reset_n;
  logic       ev_a;
  logic       left_a;
  logic       btn_a;
  logic [7:0] value_a;
  logic       drop_a;
  logic       ev_b;
  logic       left_b;
  logic       btn_b;
  logic [7:0] value_b;
  logic       drop_b;

  int total;
  int bad;
  logic seen;

  rotary_value_select_if #(.WIDTH(8)) ca ();
  rotary_value_select_if #(.WIDTH(8)) cb ();

  rotary_value_select #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(9),
    .INIT_VAL(0), .WRAP(1), .DEBOUNCE_CYCLES(8)
  ) dut_a (
    .clk(clk),
    .reset_n(reset_n),
    .rotary_event(ev_a),
    .rotary_left(left_a),
    .btn(btn_a),
    .value(value_a),
    .commit_dropped(drop_a),
    .commit(ca.master)
  );

  rotary_value_select #(
    .WIDTH(8), .MIN_VAL(3), .MAX_VAL(5),
    .INIT_VAL(4), .WRAP(0), .DEBOUNCE_CYCLES(8)
  ) dut_b (
    .clk(clk),
    .reset_n(reset_n),
    .rotary_event(ev_b),
    .rotary_left(left_b),
    .btn(btn_b),
    .value(value_b),
    .commit_dropped(drop_b),
    .commit(cb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] inc_a [11];
    logic [7:0] inc_b [3];
    logic [7:0] dec_b [4];
    inc_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6,
              8'd7, 8'd8, 8'd9, 8'd0, 8'd1};
    inc_b = '{8'd5, 8'd5, 8'd5};
    dec_b = '{8'd4, 8'd3, 8'd3, 8'd3};
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    ev_a = 0; left_a = 0; btn_a = 0;
    ev_b = 0; left_b = 0; btn_b = 0;
    ca.commit_ready = 1'b0;
    cb.commit_ready = 1'b0;
    tick();
    tick();
    chk("rst_value_a", value_a, 0);
    chk("rst_value_b", value_b, 4);
    chk("rst_valid", ca.commit_valid, 0);
    chk("rst_data", ca.commit_data, 0);
    chk("rst_drop", drop_a, 0);
    reset_n = 1'b1;

    // wrap stepping
    ev_a = 1; left_a = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("wrap_inc%0d", i), value_a, inc_a[i]);
    end
    left_a = 1;
    tick();
    chk("wrap_dec0", value_a, 0);
    tick();
    chk("wrap_dec1", value_a, 9);
    ev_a = 0;
    tick();
    chk("hold_value", value_a, 9);

    // saturating stepping
    ev_b = 1; left_b = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_inc%0d", i), value_b, inc_b[i]);
    end
    left_b = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sat_dec%0d", i), value_b, dec_b[i]);
    end
    ev_b = 0;

    // short glitch
    seen = 0;
    btn_a = 1;
    repeat (5) begin
      tick();
      if (ca.commit_valid) seen = 1;
    end
    btn_a = 0;
    repeat (20) begin
      tick();
      if (ca.commit_valid) seen = 1;
    end
    chk("glitch_no_commit", seen, 0);

    // value 9 -> 7, then a full press
    ev_a = 1; left_a = 1;
    tick();
    tick();
    ev_a = 0;
    chk("set7", value_a, 7);
    btn_a = 1;
    repeat (10) tick();
    chk("press_early", ca.commit_valid, 0);
    tick();
    chk("press_valid", ca.commit_valid, 1);
    chk("press_data", ca.commit_data, 7);

    ev_a = 1; left_a = 0;
    tick();
    tick();
    ev_a = 0;
    chk("rot_value", value_a, 9);
    chk("frozen_data", ca.commit_data, 7);

    btn_a = 0;
    repeat (12) tick();
    chk("release_valid", ca.commit_valid, 1);
    btn_a = 1;
    repeat (10) tick();
    chk("drop_early", drop_a, 0);
    tick();
    chk("drop_pulse", drop_a, 1);
    tick();
    chk("drop_end", drop_a, 0);
    chk("drop_valid", ca.commit_valid, 1);
    chk("drop_data", ca.commit_data, 7);

    ca.commit_ready = 1'b1;
    tick();
    chk("hs_valid", ca.commit_valid, 0);
    ca.commit_ready = 1'b0;
    btn_a = 0;
    repeat (12) tick();

    // value 9 -> 4, press with same-cycle increment
    ev_a = 1; left_a = 1;
    repeat (5) tick();
    ev_a = 0;
    chk("set4", value_a, 4);
    ca.commit_ready = 1'b1;
    btn_a = 1;
    repeat (10) tick();
    ev_a = 1; left_a = 0;
    tick();
    ev_a = 0;
    chk("same_valid", ca.commit_valid, 1);
    chk("same_data", ca.commit_data, 4);
    chk("same_value", value_a, 5);
    tick();
    chk("ready_hi_one_cycle", ca.commit_valid, 0);
    ca.commit_ready = 1'b0;
    btn_a = 0;
    repeat (12) tick();

    // reset during HOLD
    btn_a = 1;
    repeat (11) tick();
    chk("hold_valid", ca.commit_valid, 1);
    chk("hold_data", ca.commit_data, 5);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_hold_valid", ca.commit_valid, 0);
    chk("rst_hold_value", value_a, 0);
    chk("rst_hold_data", ca.commit_data, 0);
    tick();
    tick();
    reset_n = 1'b1;
    ev_a = 1; left_a = 0;
    tick();
    ev_a = 0;
    repeat (9) tick();
    chk("post_rst_early", ca.commit_valid, 0);
    tick();
    chk("post_rst_valid", ca.commit_valid, 1);
    chk("post_rst_data", ca.commit_data, 1);
    chk("b_no_drop", drop_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
